// File: rtl/btn_cond_pkg.sv
// Shared types and constants for the push-button conditioner.
//   btn_state_t : hold-to-repeat FSM state encoding
//   DEF_*       : cycle counts for a 50 MHz clock (10 ms / 500 ms / 100 ms)
//   cnt_width() : counter width that holds the largest of three cycle counts
package btn_cond_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,  // button released
        S_DELAY  = 2'd1,  // held, waiting for the first auto-repeat
        S_REPEAT = 2'd2   // held, periodic auto-repeat
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES     = 500_000;
    localparam int DEF_REPEAT_DELAY_CYCLES = 25_000_000;
    localparam int DEF_REPEAT_RATE_CYCLES  = 5_000_000;

    // One spare bit above the largest count keeps the terminal compare
    // well clear of wrap-around.
    function automatic int cnt_width(int a, int b, int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/btn_repeat_conditioner_if.sv
// Signal bundle between a raw button pin and its conditioner.
//   btn_raw       : raw button level, 1 = pressed (asynchronous)
//   repeat_en     : 1 = auto-repeat allowed while held
//   btn_level     : debounced level
//   press_pulse   : one-cycle pulse on accepted press
//   release_pulse : one-cycle pulse on accepted release
//   inc_pulse     : press or auto-repeat increment pulse
//   held_long     : 1 while in the auto-repeat phase
// master = the side that drives the button (pins / bench),
// slave  = the conditioner.
interface btn_repeat_conditioner_if;
    logic btn_raw;
    logic repeat_en;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic inc_pulse;
    logic held_long;

    modport master (
        output btn_raw, repeat_en,
        input  btn_level, press_pulse, release_pulse, inc_pulse, held_long
    );

    modport slave (
        input  btn_raw, repeat_en,
        output btn_level, press_pulse, release_pulse, inc_pulse, held_long
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debounce counter.
//   clk, reset   : system clock, synchronous active-high reset
//   btn_raw      : asynchronous raw button level
//   btn_level    : debounced level (registered)
//   level_toggle : combinational, 1 in the cycle whose clock edge flips
//                  btn_level; lets the parent register its edge pulses
//                  on the same edge as the level itself
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = btn_cond_pkg::DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic level_toggle
);

    logic             sync_d;
    logic             sync_q;
    logic [CNT_W-1:0] db_cnt;
    logic             differ;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchroniser
    // chain depends on this).
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_d <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync_d <= btn_raw;
            sync_q <= sync_d;
        end
    end

    assign differ       = (sync_q != btn_level);
    assign level_toggle = differ && (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // The counter measures how long sync_q has disagreed with the accepted
    // level; any agreeing cycle throws the partial count away.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_cnt    <= '0;
            btn_level <= 1'b0;
        end else if (level_toggle) begin
            db_cnt    <= '0;
            btn_level <= ~btn_level;
        end else if (differ) begin
            db_cnt    <= db_cnt + 1'b1;
        end else begin
            db_cnt    <= '0;
        end
    end

endmodule

// File: rtl/btn_repeat_conditioner.sv
// Push-button conditioner: debounce, press/release pulses and
// hold-to-repeat increment pulses.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of btn_repeat_conditioner_if
//                (btn_raw, repeat_en in; btn_level, press_pulse,
//                 release_pulse, inc_pulse, held_long out)
// All pulse outputs are registered and land on the same edge as the
// btn_level change (or the repeat counter expiry) that causes them.
module btn_repeat_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input  logic                     clk,
    input  logic                     reset,
    btn_repeat_conditioner_if.slave  bus
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES,
                                     REPEAT_RATE_CYCLES);

    logic             level;
    logic             level_toggle;
    logic             rise;
    logic             fall;

    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
    logic             delay_done;
    logic             rate_done;

    logic             press_q, release_q, inc_q, held_q;
    logic             press_nxt, release_nxt, inc_nxt, held_nxt;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .btn_raw      (bus.btn_raw),
        .btn_level    (level),
        .level_toggle (level_toggle)
    );

    // Edges of the debounced level, known one cycle before btn_level shows them.
    assign rise       = level_toggle && !level;
    assign fall       = level_toggle &&  level;
    assign delay_done = (rpt_cnt == CNT_W'(REPEAT_DELAY_CYCLES - 1));
    assign rate_done  = (rpt_cnt == CNT_W'(REPEAT_RATE_CYCLES - 1));

    // State register, repeat counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rpt_cnt   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            inc_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rpt_cnt   <= rpt_cnt_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            inc_q     <= inc_nxt;
            held_q    <= held_nxt;
        end
    end

    // Next state. Release wins over everything; a low repeat_en parks the
    // FSM in S_DELAY with a zero count so re-enabling restarts the delay.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_nxt   = state;
        rpt_cnt_nxt = rpt_cnt;
        unique case (state)
            S_IDLE: begin
                if (rise) begin
                    state_nxt   = S_DELAY;
                    rpt_cnt_nxt = '0;
                end
            end
            S_DELAY: begin
                if (fall) begin
                    state_nxt   = S_IDLE;
                    rpt_cnt_nxt = '0;
                end else if (!bus.repeat_en) begin
                    rpt_cnt_nxt = '0;
                end else if (delay_done) begin
                    state_nxt   = S_REPEAT;
                    rpt_cnt_nxt = '0;
                end else begin
                    rpt_cnt_nxt = rpt_cnt + 1'b1;
                end
            end
            S_REPEAT: begin
                if (fall) begin
                    state_nxt   = S_IDLE;
                    rpt_cnt_nxt = '0;
                end else if (!bus.repeat_en) begin
                    state_nxt   = S_DELAY;
                    rpt_cnt_nxt = '0;
                end else if (rate_done) begin
                    rpt_cnt_nxt = '0;
                end else begin
                    rpt_cnt_nxt = rpt_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                rpt_cnt_nxt = '0;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        press_nxt   = rise;
        release_nxt = fall;
        inc_nxt     = 1'b0;
        held_nxt    = 1'b0;
        unique case (state)
            S_IDLE: begin
                inc_nxt = rise;
            end
            S_DELAY: begin
                if (!fall && bus.repeat_en && delay_done) begin
                    inc_nxt  = 1'b1;
                    held_nxt = 1'b1;
                end
            end
            S_REPEAT: begin
                if (!fall && bus.repeat_en) begin
                    held_nxt = 1'b1;
                    inc_nxt  = rate_done;
                end
            end
            default: begin
                inc_nxt  = 1'b0;
                held_nxt = 1'b0;
            end
        endcase
    end

    assign bus.btn_level     = level;
    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.inc_pulse     = inc_q;
    assign bus.held_long     = held_q;

endmodule

// File: tb/tb_btn_repeat_conditioner.sv
// Self-checking bench for btn_repeat_conditioner with DEBOUNCE=4,
// DELAY=10, RATE=3. A timeline reference model predicts every output on
// every cycle; directed scenarios additionally check event cycle lists.
module tb_btn_repeat_conditioner;

    localparam int DEB  = 4;
    localparam int DEL  = 10;
    localparam int RATE = 3;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic reset;

    btn_repeat_conditioner_if bus ();

    btn_repeat_conditioner #(
        .DEBOUNCE_CYCLES     (DEB),
        .REPEAT_DELAY_CYCLES (DEL),
        .REPEAT_RATE_CYCLES  (RATE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus values for the current cycle.
    logic raw_v, en_v, rst_v;
    int   cyc = 0;
    int   t0  = 0;

    // Reference model: raw history plus a few timeline anchors.
    logic raw_h [MAXC];
    int   last_rst = -10;
    int   last_chg = 0;
    int   anchor   = 0;
    logic m_lvl    = 1'b0;
    logic e_lvl, e_press, e_rel, e_inc, e_hl;
    logic prev_inc = 1'b0;

    // Scenario event logs, cycle numbers relative to t0.
    int   ev_press[$];
    int   ev_rel[$];
    int   ev_inc[$];
    int   hl_on, hl_off;
    logic lvl_seen;
    int   exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc - t0);
        end
    endtask

    task automatic check_list(input string tag, input int got[$], input int exp[$]);
        check({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            check(tag, got[i], exp[i]);
    endtask

    // Synchronised raw level seen by the debouncer in cycle t: raw delayed
    // two cycles, zero for the first two cycles after a reset.
    function automatic logic sq_at(input int t);
        if (t - 2 > last_rst) return raw_h[t-2];
        return 1'b0;
    endfunction

    // Predict the outputs visible in cycle t+1 from the inputs of cycle t.
    task automatic model_step(input int t, input logic raw, input logic en, input logic rst);
        logic nlvl, all_diff, pr, rl;
        int   d;
        raw_h[t] = raw;
        if (rst) begin
            last_rst = t;
            last_chg = t + 1;
            m_lvl    = 1'b0;
            {e_lvl, e_press, e_rel, e_inc, e_hl} = '0;
            return;
        end
        // A level change is accepted once the synchronised input has
        // disagreed with the level for DEB consecutive cycles, all of them
        // after the last level change or reset.
        nlvl = m_lvl;
        if (t - DEB + 1 >= last_chg) begin
            all_diff = 1'b1;
            for (int k = t - DEB + 1; k <= t; k++)
                if (sq_at(k) == m_lvl) all_diff = 1'b0;
            if (all_diff) begin
                nlvl     = ~m_lvl;
                last_chg = t + 1;
            end
        end
        pr    = nlvl & ~m_lvl;
        rl    = ~nlvl & m_lvl;
        e_inc = 1'b0;
        e_hl  = 1'b0;
        if (pr) begin
            anchor = t + 1;
            e_inc  = 1'b1;
        end else if (nlvl) begin
            if (!en) begin
                anchor = t + 1;
            end else begin
                // Repeats at anchor+DEL, then every RATE cycles.
                d     = t + 1 - anchor;
                e_hl  = (d >= DEL);
                e_inc = (d >= DEL) && ((d - DEL) % RATE == 0);
            end
        end
        m_lvl   = nlvl;
        e_lvl   = nlvl;
        e_press = pr;
        e_rel   = rl;
    endtask

    task automatic tick();
        bus.btn_raw   = raw_v;
        bus.repeat_en = en_v;
        reset         = rst_v;
        model_step(cyc, raw_v, en_v, rst_v);
        @(posedge clk);
        #1;
        cyc++;
        check("btn_level",     int'(bus.btn_level),     int'(e_lvl));
        check("press_pulse",   int'(bus.press_pulse),   int'(e_press));
        check("release_pulse", int'(bus.release_pulse), int'(e_rel));
        check("inc_pulse",     int'(bus.inc_pulse),     int'(e_inc));
        check("held_long",     int'(bus.held_long),     int'(e_hl));
        check("inc_back_to_back", int'(prev_inc && bus.inc_pulse), 0);
        prev_inc = bus.inc_pulse;
        if (bus.press_pulse)   ev_press.push_back(cyc - t0);
        if (bus.release_pulse) ev_rel.push_back(cyc - t0);
        if (bus.inc_pulse)     ev_inc.push_back(cyc - t0);
        if (bus.btn_level)     lvl_seen = 1'b1;
        if (bus.held_long && hl_on < 0) hl_on = cyc - t0;
        if (!bus.held_long && hl_on >= 0 && hl_off < 0) hl_off = cyc - t0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic begin_scn();
        t0 = cyc;
        ev_press.delete();
        ev_rel.delete();
        ev_inc.delete();
        hl_on    = -1;
        hl_off   = -1;
        lvl_seen = 1'b0;
    endtask

    initial begin
        logic bounce [9];
        int   run;

        // ---- Reset held with the button pressed ----
        raw_v = 1'b1; en_v = 1'b1; rst_v = 1'b1;
        begin_scn();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_outputs", int'({bus.btn_level, bus.press_pulse, bus.release_pulse,
                                       bus.inc_pulse, bus.held_long}), 0);
        end
        rst_v = 1'b0;
        begin_scn();
        idle(8);
        exp_q = {6};
        check_list("rst_press", ev_press, exp_q);
        raw_v = 1'b0;
        idle(20);

        // ---- Clean press ----
        begin_scn();
        raw_v = 1'b1;
        idle(8);
        exp_q = {6};
        check_list("clean_press", ev_press, exp_q);
        check_list("clean_inc", ev_inc, exp_q);
        raw_v = 1'b0;
        idle(20);

        // ---- Bounce shorter than the debounce window ----
        begin_scn();
        bounce = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 9; i++) begin
            raw_v = bounce[i];
            tick();
        end
        raw_v = 1'b0;
        idle(10);
        exp_q = {};
        check_list("bounce_press", ev_press, exp_q);
        check_list("bounce_inc", ev_inc, exp_q);
        check_list("bounce_rel", ev_rel, exp_q);
        check("bounce_level", int'(lvl_seen), 0);
        begin_scn();
        raw_v = 1'b1;
        idle(8);
        exp_q = {6};
        check_list("post_bounce_press", ev_press, exp_q);
        raw_v = 1'b0;
        idle(20);

        // ---- Hold with repeat; release lands on a repeat expiry ----
        begin_scn();
        for (int i = 0; i < 40; i++) begin
            raw_v = (i < 22);
            tick();
        end
        exp_q = {6, 16, 19, 22, 25};
        check_list("hold_inc", ev_inc, exp_q);
        exp_q = {28};
        check_list("hold_rel", ev_rel, exp_q);
        check("hold_hl_on", hl_on, 16);
        check("hold_hl_off", hl_off, 28);
        idle(10);

        // ---- repeat_en low while held, raised at cycle 30 ----
        begin_scn();
        raw_v = 1'b1;
        for (int i = 0; i < 45; i++) begin
            en_v = (i >= 30);
            tick();
        end
        exp_q = {6, 40, 43};
        check_list("en_inc", ev_inc, exp_q);
        exp_q = {6};
        check_list("en_press", ev_press, exp_q);
        check("en_hl_on", hl_on, 40);
        raw_v = 1'b0;
        en_v  = 1'b1;
        idle(20);

        // ---- Reset in the middle of a repeat ----
        begin_scn();
        raw_v = 1'b1;
        for (int i = 0; i < 42; i++) begin
            rst_v = (i == 20);
            tick();
            if (cyc - t0 == 21)
                check("midrst_outputs", int'({bus.btn_level, bus.press_pulse, bus.release_pulse,
                                              bus.inc_pulse, bus.held_long}), 0);
        end
        rst_v = 1'b0;
        exp_q = {6, 16, 19, 27, 37, 40};
        check_list("midrst_inc", ev_inc, exp_q);
        exp_q = {6, 27};
        check_list("midrst_press", ev_press, exp_q);
        exp_q = {};
        check_list("midrst_rel", ev_rel, exp_q);
        raw_v = 1'b0;
        idle(20);

        // ---- Randomised runs of press / bounce / hold with repeat_en and reset noise ----
        begin_scn();
        for (int blk = 0; blk < 120; blk++) begin
            raw_v = $urandom_range(0, 1);
            run   = (raw_v && ($urandom_range(0, 3) == 0)) ? $urandom_range(15, 40)
                                                           : $urandom_range(1, 8);
            for (int i = 0; i < run; i++) begin
                if ($urandom_range(0, 19) == 0) en_v = ~en_v;
                rst_v = ($urandom_range(0, 199) == 0);
                tick();
            end
        end
        rst_v = 1'b0;
        raw_v = 1'b0;
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
